// File: rtl/axis_sched_pkg.sv
// Shared types and constants for the AXI-stream budget arbiter.
package axis_sched_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } arb_state_e;

  // Wide all-ones pattern; users truncate it to their budget width.
  localparam logic [63:0] BUDGET_UNLIMITED = '1;

  function automatic int port_idx_w(input int n_ports);
    return (n_ports > 1) ? $clog2(n_ports) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Rotating-priority encoder: first requester strictly after last_grant_i, wrapping.
module rr_priority_select
  import axis_sched_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = port_idx_w(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] last_grant_i,
  output logic             grant_valid_o,
  output logic [IDX_W-1:0] grant_idx_o
);

  logic [IDX_W-1:0] cand_s;
  logic             hit_s;

  // Scan offsets 1..N from the last grant; the first hit wins.
  always_comb begin
    grant_valid_o = 1'b0;
    grant_idx_o   = '0;
    cand_s        = '0;
    hit_s         = 1'b0;
    for (int k = 1; k <= N; k++) begin
      cand_s        = IDX_W'((int'(last_grant_i) + k) % N);
      hit_s         = req_i[cand_s] && !grant_valid_o;
      grant_idx_o   = hit_s ? cand_s : grant_idx_o;
      grant_valid_o = grant_valid_o | hit_s;
    end
  end

endmodule

// File: rtl/axis_budget_arbiter.sv
// Packet-granular round-robin AXI-stream arbiter with per-port beat budgets per window.
// Optional AXIS_BUDGET_WORK_CONSERVING_EN lets over-budget ports use an otherwise idle link.
module axis_budget_arbiter
  import axis_sched_pkg::*;
#(
  parameter int N_PORTS      = 4,
  parameter int DATA_WIDTH   = 512,
  parameter int KEEP_WIDTH   = DATA_WIDTH / 8,
  parameter int WINDOW_WIDTH = 16,
  parameter int BUDGET_WIDTH = 16,
  localparam int IDX_W       = port_idx_w(N_PORTS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_PORTS*DATA_WIDTH-1:0]   s_axis_tdata_i,
  input  logic [N_PORTS*KEEP_WIDTH-1:0]   s_axis_tkeep_i,
  input  logic [N_PORTS-1:0]              s_axis_tvalid_i,
  input  logic [N_PORTS-1:0]              s_axis_tlast_i,
  output logic [N_PORTS-1:0]              s_axis_tready_o,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata_o,
  output logic [KEEP_WIDTH-1:0]           m_axis_tkeep_o,
  output logic                            m_axis_tvalid_o,
  output logic                            m_axis_tlast_o,
  input  logic                            m_axis_tready_i,
  output logic [IDX_W-1:0]                m_axis_tid_o,
  input  logic [N_PORTS*BUDGET_WIDTH-1:0] cfg_budget_i,
  output logic [N_PORTS*BUDGET_WIDTH-1:0] stat_beats_o,
  output logic                            stat_window_done_o
);

  localparam logic [BUDGET_WIDTH-1:0] UNLIM = BUDGET_WIDTH'(BUDGET_UNLIMITED);
  localparam logic [BUDGET_WIDTH-1:0] ONE   = {{(BUDGET_WIDTH-1){1'b0}}, 1'b1};

  arb_state_e                             state_q, state_d;
  logic [IDX_W-1:0]                       sel_q, sel_d, last_grant_q, last_grant_d;
  logic [WINDOW_WIDTH-1:0]                win_ctr_q;
  logic [N_PORTS-1:0][BUDGET_WIDTH-1:0]   used_q, used_d, budget_q, stat_q, stat_d;
  logic                                   stat_done_q;

  logic [N_PORTS-1:0][DATA_WIDTH-1:0]     s_data_s;
  logic [N_PORTS-1:0][KEEP_WIDTH-1:0]     s_keep_s;
  logic [N_PORTS-1:0]                     eligible_s, port_beat_s;
  logic                                   boundary_s, xfer_s, beat_s, last_beat_s;
  logic                                   elig_valid_s, pick_valid_s;
  logic [IDX_W-1:0]                       elig_idx_s, pick_idx_s;

  assign s_data_s   = s_axis_tdata_i;
  assign s_keep_s   = s_axis_tkeep_i;
  assign boundary_s = (win_ctr_q == '0);
  assign xfer_s     = (state_q == ST_XFER);
  assign beat_s     = xfer_s && s_axis_tvalid_i[sel_q] && m_axis_tready_i;
  assign last_beat_s = beat_s && s_axis_tlast_i[sel_q];

  // Per-port eligibility, output ready steering and beat attribution.
  always_comb begin
    eligible_s      = '0;
    port_beat_s     = '0;
    s_axis_tready_o = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      eligible_s[i]      = s_axis_tvalid_i[i] &&
                           ((used_q[i] < budget_q[i]) || (budget_q[i] == UNLIM));
      s_axis_tready_o[i] = xfer_s && m_axis_tready_i && (sel_q == IDX_W'(i));
      port_beat_s[i]     = beat_s && (sel_q == IDX_W'(i));
    end
  end

  rr_priority_select #(.N(N_PORTS), .IDX_W(IDX_W)) u_sel_elig (
    .req_i         (eligible_s),
    .last_grant_i  (last_grant_q),
    .grant_valid_o (elig_valid_s),
    .grant_idx_o   (elig_idx_s)
  );

`ifdef AXIS_BUDGET_WORK_CONSERVING_EN
  logic [N_PORTS-1:0] spare_req_s;
  logic               spare_valid_s;
  logic [IDX_W-1:0]   spare_idx_s;

  // Over-budget fallback set; a zero budget still means blocked.
  always_comb begin
    spare_req_s = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      spare_req_s[i] = s_axis_tvalid_i[i] && (budget_q[i] != '0);
    end
  end

  rr_priority_select #(.N(N_PORTS), .IDX_W(IDX_W)) u_sel_spare (
    .req_i         (spare_req_s),
    .last_grant_i  (last_grant_q),
    .grant_valid_o (spare_valid_s),
    .grant_idx_o   (spare_idx_s)
  );

  assign pick_valid_s = elig_valid_s | spare_valid_s;
  assign pick_idx_s   = elig_valid_s ? elig_idx_s : spare_idx_s;
`else
  assign pick_valid_s = elig_valid_s;
  assign pick_idx_s   = elig_idx_s;
`endif

  // Grant FSM next state.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid_s) begin
          state_d      = ST_XFER;
          sel_d        = pick_idx_s;
          last_grant_d = pick_idx_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_XFER: begin
        if (last_beat_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_XFER;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Usage counters; the boundary-cycle beat opens the new window.
  always_comb begin
    used_d = used_q;
    stat_d = stat_q;
    for (int i = 0; i < N_PORTS; i++) begin
      if (boundary_s) begin
        stat_d[i] = used_q[i];
        used_d[i] = port_beat_s[i] ? ONE : '0;
      end else begin
        used_d[i] = (port_beat_s[i] && (used_q[i] != UNLIM)) ? used_q[i] + ONE : used_q[i];
      end
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sel_q        <= '0;
      last_grant_q <= IDX_W'(N_PORTS - 1);
      win_ctr_q    <= '0;
      used_q       <= '0;
      budget_q     <= '0;
      stat_q       <= '0;
      stat_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      last_grant_q <= last_grant_d;
      win_ctr_q    <= win_ctr_q + 1'b1;
      used_q       <= used_d;
      stat_q       <= stat_d;
      stat_done_q  <= boundary_s;
      if (boundary_s) begin
        budget_q <= cfg_budget_i;
      end
    end
  end

  assign m_axis_tdata_o     = s_data_s[sel_q];
  assign m_axis_tkeep_o     = s_keep_s[sel_q];
  assign m_axis_tvalid_o    = xfer_s && s_axis_tvalid_i[sel_q];
  assign m_axis_tlast_o     = xfer_s && s_axis_tlast_i[sel_q];
  assign m_axis_tid_o       = sel_q;
  assign stat_beats_o       = stat_q;
  assign stat_window_done_o = stat_done_q;

endmodule

// File: tb/tb_axis_budget_arbiter.sv
// Directed self-checking bench for axis_budget_arbiter (4 ports, 64-cycle window).
module tb_axis_budget_arbiter;

  localparam int NP = 4;
  localparam int DW = 32;
  localparam int KW = 4;
  localparam int WW = 6;
  localparam int BW = 8;

`ifdef AXIS_BUDGET_WORK_CONSERVING_EN
  localparam bit WC = 1'b1;
`else
  localparam bit WC = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NP*DW-1:0] s_tdata;
  logic [NP*KW-1:0] s_tkeep;
  logic [NP-1:0]    s_tvalid, s_tlast, s_tready;
  logic [DW-1:0]    m_tdata;
  logic [KW-1:0]    m_tkeep;
  logic             m_tvalid, m_tlast, m_tready;
  logic [1:0]       m_tid;
  logic [NP*BW-1:0] cfg_budget, stat_beats;
  logic             stat_done;

  logic [NP-1:0]    src_en;
  int               first_len [NP];
  int               next_len  [NP];
  logic [7:0]       beat_cnt  [NP];
  logic [15:0]      pkt_cnt   [NP];

  int checks = 0;
  int failures = 0;
  int cur = 0;

  always #5 clk = ~clk;

  axis_budget_arbiter #(
    .N_PORTS(NP), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .WINDOW_WIDTH(WW), .BUDGET_WIDTH(BW)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata_i(s_tdata), .s_axis_tkeep_i(s_tkeep), .s_axis_tvalid_i(s_tvalid),
    .s_axis_tlast_i(s_tlast), .s_axis_tready_o(s_tready),
    .m_axis_tdata_o(m_tdata), .m_axis_tkeep_o(m_tkeep), .m_axis_tvalid_o(m_tvalid),
    .m_axis_tlast_o(m_tlast), .m_axis_tready_i(m_tready), .m_axis_tid_o(m_tid),
    .cfg_budget_i(cfg_budget), .stat_beats_o(stat_beats), .stat_window_done_o(stat_done)
  );

  // Source model: beat/packet counters advance on each accepted beat.
  always @(posedge clk) begin
    for (int p = 0; p < NP; p++) begin
      if (rst) begin
        beat_cnt[p] <= 8'd0;
        pkt_cnt[p]  <= 16'd0;
      end else if (s_tvalid[p] && s_tready[p]) begin
        if (s_tlast[p]) begin
          beat_cnt[p] <= 8'd0;
          pkt_cnt[p]  <= pkt_cnt[p] + 16'd1;
        end else begin
          beat_cnt[p] <= beat_cnt[p] + 8'd1;
        end
      end
    end
  end

  always_comb begin
    s_tvalid = '0;
    s_tlast  = '0;
    s_tdata  = '0;
    s_tkeep  = '0;
    for (int p = 0; p < NP; p++) begin
      s_tvalid[p]          = src_en[p];
      s_tlast[p]           = (int'(beat_cnt[p]) ==
                              ((pkt_cnt[p] == 16'd0) ? first_len[p] : next_len[p]) - 1);
      s_tdata[p*DW +: DW]  = {8'(p), beat_cnt[p], pkt_cnt[p]};
      s_tkeep[p*KW +: KW]  = 4'hF ^ 4'(p);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cur);
    end
  endtask

  task automatic to_cycle(input int k);
    while (cur < k) begin
      @(posedge clk);
      #1;
      cur++;
    end
  endtask

  task automatic at(input int k);
    to_cycle(k);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cur = 0;
  endtask

  task automatic set_src(input logic [NP-1:0] en, input int flen, input int nlen);
    src_en = en;
    for (int p = 0; p < NP; p++) begin
      first_len[p] = flen;
      next_len[p]  = nlen;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state while rst is held
    m_tready   = 1'b1;
    cfg_budget = {8'd8, 8'd8, 8'd8, 8'd8};
    set_src(4'b1111, 1, 1);
    @(posedge clk);
    @(negedge clk);
    check_eq("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
    check_eq("rst_tready", {28'd0, s_tready}, 32'd0);
    check_eq("rst_tid", {30'd0, m_tid}, 32'd0);
    check_eq("rst_stat", stat_beats, 32'd0);
    check_eq("rst_done", {31'd0, stat_done}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cur = 0;

    // Equal budgets, 1-beat packets on all ports
    at(0);   check_eq("t1_c0_tvalid", {31'd0, m_tvalid}, 32'd0);
    at(1);   check_eq("t1_c1_tvalid", {31'd0, m_tvalid}, 32'd0);
             check_eq("t1_c1_done", {31'd0, stat_done}, 32'd1);
    at(2);   check_eq("t1_c2_tvalid", {31'd0, m_tvalid}, 32'd1);
             check_eq("t1_c2_tid", {30'd0, m_tid}, 32'd0);
             check_eq("t1_c2_data", m_tdata, 32'h0000_0000);
             check_eq("t1_c2_tready", {28'd0, s_tready}, 32'h1);
             check_eq("t1_c2_tkeep", {28'd0, m_tkeep}, 32'hF);
    at(3);   check_eq("t1_gap_tvalid", {31'd0, m_tvalid}, 32'd0);
             check_eq("t1_gap_tready", {28'd0, s_tready}, 32'h0);
    at(4);   check_eq("t1_c4_tid", {30'd0, m_tid}, 32'd1);
             check_eq("t1_c4_data", m_tdata, 32'h0100_0000);
    at(8);   check_eq("t1_c8_tid", {30'd0, m_tid}, 32'd3);
    at(10);  check_eq("t1_c10_tid", {30'd0, m_tid}, 32'd0);
             check_eq("t1_c10_data", m_tdata, 32'h0000_0001);
    at(64);  check_eq("t1_c64_done", {31'd0, stat_done}, 32'd0);
             check_eq("t1_c64_tid", {30'd0, m_tid}, 32'd3);
             check_eq("t1_c64_tvalid", {31'd0, m_tvalid}, 32'd1);
    at(65);  check_eq("t1_w0_done", {31'd0, stat_done}, 32'd1);
             check_eq("t1_w0_stat", stat_beats, {8'd7, 8'd8, 8'd8, 8'd8});
    at(66);  check_eq("t1_c66_done", {31'd0, stat_done}, 32'd0);
    at(129); check_eq("t1_w1_done", {31'd0, stat_done}, 32'd1);
             check_eq("t1_w1_stat", stat_beats, {8'd8, 8'd8, 8'd8, 8'd8});

    // Budgets {16,4,0,unlimited}
    cfg_budget = {8'd255, 8'd0, 8'd4, 8'd16};
    set_src(4'b1111, 1, 1);
    do_reset();
    at(65);  check_eq("t2_w0_stat", stat_beats, {8'd13, 8'd0, 8'd4, 8'd14});
    at(129); check_eq("t2_w1_stat", stat_beats, {8'd14, 8'd0, 8'd4, 8'd14});

    // Budget exhausted mid-packet on port 0
    cfg_budget = {8'd0, 8'd0, 8'd0, 8'd2};
    set_src(4'b0001, 1, 8);
    do_reset();
    at(2);   check_eq("t3_c2_tlast", {31'd0, m_tlast}, 32'd1);
    at(3);   check_eq("t3_c3_tvalid", {31'd0, m_tvalid}, 32'd0);
    for (int k = 0; k < 8; k++) begin
      at(4 + k);
      check_eq("t3_pkt_tvalid", {31'd0, m_tvalid}, 32'd1);
      check_eq("t3_pkt_data", m_tdata, {8'd0, 8'(k), 16'd1});
    end
    check_eq("t3_pkt_tlast", {31'd0, m_tlast}, 32'd1);
    at(12);  check_eq("t3_c12_tvalid", {31'd0, m_tvalid}, 32'd0);
    at(40);  check_eq("t3_c40_tvalid", {31'd0, m_tvalid}, 32'd0);
    at(65);  check_eq("t3_w0_stat", stat_beats, {8'd0, 8'd0, 8'd0, 8'd9});
             check_eq("t3_c65_tvalid", {31'd0, m_tvalid}, 32'd0);
    at(66);  check_eq("t3_c66_tvalid", {31'd0, m_tvalid}, 32'd1);

    // Downstream stall inside a 4-beat packet from port 1
    m_tready   = 1'b1;
    cfg_budget = {8'd0, 8'd0, 8'd4, 8'd0};
    set_src(4'b0010, 4, 4);
    do_reset();
    at(2);   check_eq("t4_c2_tready", {28'd0, s_tready}, 32'h2);
             check_eq("t4_c2_data", m_tdata, 32'h0100_0000);
    to_cycle(3);
    m_tready = 1'b0;
    @(negedge clk);
    check_eq("t4_stall_tready", {28'd0, s_tready}, 32'h0);
    check_eq("t4_stall_tvalid", {31'd0, m_tvalid}, 32'd1);
    check_eq("t4_stall_data", m_tdata, 32'h0101_0000);
    check_eq("t4_stall_tkeep", {28'd0, m_tkeep}, 32'hE);
    to_cycle(4);
    m_tready = 1'b1;
    @(negedge clk);
    check_eq("t4_resume_tready", {28'd0, s_tready}, 32'h2);
    check_eq("t4_resume_data", m_tdata, 32'h0101_0000);
    at(6);   check_eq("t4_c6_tlast", {31'd0, m_tlast}, 32'd1);
    at(7);   check_eq("t4_c7_tvalid", {31'd0, m_tvalid}, 32'd0);
             check_eq("t4_c7_tid", {30'd0, m_tid}, 32'd1);
    at(20);  check_eq("t4_c20_tvalid", {31'd0, m_tvalid}, 32'd0);
    at(65);  check_eq("t4_w0_stat", stat_beats, {8'd0, 8'd0, 8'd4, 8'd0});

    // Small budgets {4,4,0,4}: idle link or work-conserving sharing
    cfg_budget = {8'd4, 8'd0, 8'd4, 8'd4};
    set_src(4'b1111, 1, 1);
    do_reset();
    at(24);  check_eq("t5_c24_tid", {30'd0, m_tid}, 32'd3);
    at(26);  check_eq("t5_c26_tvalid", {31'd0, m_tvalid}, WC ? 32'd1 : 32'd0);
    at(40);  check_eq("t5_c40_tvalid", {31'd0, m_tvalid}, WC ? 32'd1 : 32'd0);
    at(65);  check_eq("t5_w0_stat", stat_beats,
                      WC ? {8'd10, 8'd0, 8'd10, 8'd11} : {8'd4, 8'd0, 8'd4, 8'd4});

    // Reset on the third beat of a 5-beat packet
    cfg_budget = {8'd0, 8'd10, 8'd0, 8'd0};
    set_src(4'b0100, 5, 5);
    do_reset();
    at(4);   check_eq("t6_c4_tvalid", {31'd0, m_tvalid}, 32'd1);
             check_eq("t6_c4_tid", {30'd0, m_tid}, 32'd2);
             check_eq("t6_c4_data", m_tdata, 32'h0202_0000);
    do_reset();
    at(0);   check_eq("t6_r0_tvalid", {31'd0, m_tvalid}, 32'd0);
             check_eq("t6_r0_tready", {28'd0, s_tready}, 32'h0);
             check_eq("t6_r0_tid", {30'd0, m_tid}, 32'd0);
    at(1);   check_eq("t6_r1_tvalid", {31'd0, m_tvalid}, 32'd0);
             check_eq("t6_r1_stat", stat_beats, 32'd0);
    at(2);   check_eq("t6_r2_tvalid", {31'd0, m_tvalid}, 32'd1);
             check_eq("t6_r2_tid", {30'd0, m_tid}, 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis_budget_arbiter.md
# axis_budget_arbiter

Packet-granular round-robin arbiter that shares one AXI-stream output link among N_PORTS requesters, with a per-port beat budget per fixed window of 2^WINDOW_WIDTH cycles. It sits in front of the shared transmit datapath and enforces bandwidth shares between queue pairs. It reports per-window beat counts using the same windowing as the bandwidth-usage monitor, so the two can be compared directly.

## Interface
- N_PORTS, 4, number of requesters (2..16)
- DATA_WIDTH, 512, tdata width
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width
- WINDOW_WIDTH, 16, window length = 2^WINDOW_WIDTH clk cycles
- BUDGET_WIDTH, 16, width of budget and statistic counters
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- s_axis_tdata  in  N_PORTS*DATA_WIDTH  per-port data, port i at slice i
- s_axis_tkeep  in  N_PORTS*KEEP_WIDTH  per-port keep
- s_axis_tvalid  in  N_PORTS  per-port valid
- s_axis_tlast  in  N_PORTS  per-port last
- s_axis_tready  out  N_PORTS  per-port ready
- m_axis_tdata / m_axis_tkeep  out  DATA_WIDTH / KEEP_WIDTH  muxed data / keep
- m_axis_tvalid, m_axis_tlast  out  1  muxed valid, last
- m_axis_tready  in  1  downstream ready
- m_axis_tid  out  $clog2(N_PORTS)  index of the granted port
- cfg_budget  in  N_PORTS*BUDGET_WIDTH  beats allowed per window; 0 = blocked; all-ones = unlimited
- stat_beats  out  N_PORTS*BUDGET_WIDTH  beats sent per port in the last completed window
- stat_window_done  out  1  one-cycle pulse when stat_beats updates

## Operation
- Window counter `win_ctr` (WINDOW_WIDTH bits) is free-running and wraps. The cycle where `win_ctr==0` is the boundary.
- At the boundary:
  - `cfg_budget` is latched into `budget_q`.
  - `stat_beats` is loaded with `used[i]`, excluding any beat in the boundary cycle itself.
  - `used[i]` is set to 1 if port i transfers a beat in that cycle, otherwise 0.
  - `stat_window_done` pulses on the following cycle, aligned with the `stat_beats` update.
- `used[i]` increments on every m-side handshake while port i is granted. It saturates at all-ones.
- Eligibility:
  - Port i is eligible when `s_axis_tvalid[i]` is high and (`used[i] < budget_q[i]` or `budget_q[i]` is all-ones).
  - The budget is checked only at packet start. A granted packet always completes, even if its budget is exhausted mid-packet.
- Two states:
  - IDLE: the rotating-priority select picks the first eligible port after `last_grant`. If one is found, `sel` and `last_grant` are registered and the state moves to XFER. Otherwise the state stays IDLE.
  - XFER: straight-through passthrough.
    - `m_axis_*` = `s_axis_*[sel]`.
    - `s_axis_tready[i]` = `m_axis_tready` && i==`sel`.
    - A handshake with tlast moves the state to IDLE.
- `m_axis_tvalid`, `m_axis_tlast`, and all `s_axis_tready` are 0 in IDLE. `m_axis_tid` = `sel` and holds its value in IDLE.

## Timing
- Reset values:
  - state IDLE; `last_grant` = N_PORTS-1, so port 0 wins first.
  - `win_ctr`, `used`, `stat_beats`, `sel`, `m_axis_tid`: 0.
  - `budget_q` = 0: no port is eligible until the first boundary after reset.
  - `m_axis_tvalid`, `s_axis_tready`, `stat_window_done`: 0.
- Reset mid-packet aborts the grant immediately. Recovering the truncated packet is the upstream's responsibility.
- Grant latency: eligible in IDLE at cycle t → XFER at t+1, with the first beat possible at t+1.
- Inter-packet gap: exactly one IDLE cycle after each tlast.
- Data path is combinational in XFER (zero added latency). Registering it is the job of a downstream axis register slice.
- A `cfg_budget` change takes effect only at the next boundary.

## Configuration
- `AXIS_BUDGET_WORK_CONSERVING_EN` defined:
  - In IDLE, if no port is eligible but some port is valid, the valid over-budget ports are granted round-robin.
  - Their beats still count into `used` (saturating).
  - Ports with budget 0 are never granted.
- Macro undefined: over-budget ports wait for the next window boundary, and the link idles.

## Structure
- Package `axis_sched_pkg` holds:
  - the state enum (IDLE, XFER)
  - the port-index width constant
  - the budget "unlimited" constant (all-ones)
- Sub-module `rr_priority_select`: combinational rotating-priority encoder. Inputs are request vector and `last_grant`; outputs are `grant_valid` and `grant_idx`. It is instantiated once, or twice in work-conserving mode (the eligible set first, then the valid set).

## Test plan
Unless stated, tests use WINDOW_WIDTH=6 (64 cycles) and N_PORTS=4.
1. Reset, then all ports valid with 1-beat packets and budgets {8,8,8,8}, `m_axis_tready`=1 → grants in order 0,1,2,3,0…; each port sends 8 beats per window; `stat_beats` = {8,8,8,8}; `stat_window_done` pulses every 64 cycles.
2. Budgets {16,4,0,all-ones}, all saturating with 1-beat packets, macro undefined → per window, port 1 gets exactly 4 beats and port 2 gets 0; port 0 gets 16 unless port 3 starves it; the `stat_beats` sum never exceeds 32 (one beat per two cycles).
3. Port 0 budget 2; it starts an 8-beat packet with `used`=1 → the whole packet completes with 8 contiguous beats; `stat_beats[0]`=9; no new grant to port 0 until the next boundary.
4. `m_axis_tready` toggled 1-0-1 during a packet from port 1 → `s_axis_tready[1]` follows it; data stays stable while stalled; `used[1]` counts only handshakes.
5. Same traffic as test 2 with `AXIS_BUDGET_WORK_CONSERVING_EN` → after budgets are exhausted, ports 0, 1 and 3 keep sharing the link; port 2 is still 0; the link is never idle while an eligible port has valid data.
6. `rst` asserted on the third beat of a 5-beat packet → next cycle `m_axis_tvalid`=0 and all `s_axis_tready`=0; no grant until `budget_q` is reloaded at the next boundary.
